data_memory_lsu: RTL

Parametrised successor to the single-port word data memory. It adds byte, halfword and word access with per-byte write lanes, and sign/zero extension on loads. It also adds a registered synchronous read, a valid/ready request/response handshake, and misalignment/bounds error reporting. It sits between the core's MEM stage and the data RAM array, replacing the tri-stated combinational read path.

---
 rtl/data_memory_lsu_if.sv | 22 ++
 rtl/data_memory_lsu.sv | 76 +++++++
 2 files changed

// File: rtl/data_memory_lsu_if.sv
// data_memory_lsu_if: request/response handshake bundle between the MEM stage and the data memory LSU
interface data_memory_lsu_if #(parameter int ADDR_W = 32);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_error;
  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );
  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/data_memory_lsu.sv
// data_memory_lsu: byte/half/word data memory with registered read and error reporting; DMEM_BOUNDS_CHECK_EN enables range errors
module data_memory_lsu #(
  parameter int                DEPTH_WORDS = 256,
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
  input logic              clock,
  input logic              reset,
  data_memory_lsu_if.slave bus
);
  localparam int IW = $clog2(DEPTH_WORDS);
  typedef enum logic {IDLE, RESP} state_t;
  state_t state_q, state_d;
  logic [31:0] mem [DEPTH_WORDS];
  logic [ADDR_W-1:0] offset;
  logic [IW-1:0] idx;
  logic [1:0] lane;
  logic oor, err, accept, we;
  logic [3:0] be;
  logic [31:0] wd, rword, ld, rdata_q;
  logic [7:0] rbyte;
  logic [15:0] rhalf;
  logic error_q;
  assign offset = bus.req_addr - BASE_ADDR;
  assign idx    = offset[IW+1:2];
  assign lane   = offset[1:0];
`ifdef DMEM_BOUNDS_CHECK_EN
  assign oor = |offset[ADDR_W-1:IW+2];
`else
  logic unused_hi;
  assign unused_hi = ^offset[ADDR_W-1:IW+2];
  assign oor = 1'b0;
`endif
  assign err = (bus.req_size == 2'b11) || (bus.req_size == 2'b01 && lane[0]) ||
               (bus.req_size == 2'b10 && lane != 2'b00) || oor;
  assign bus.req_ready = (state_q == IDLE) && !reset;
  assign accept = bus.req_valid && bus.req_ready;
  assign we     = accept && bus.req_write && !err;
  assign be = bus.req_size == 2'b00 ? 4'b0001 << lane :
              bus.req_size == 2'b01 ? 4'b0011 << lane : 4'b1111;
  assign wd = bus.req_size == 2'b00 ? {4{bus.req_wdata[7:0]}} :
              bus.req_size == 2'b01 ? {2{bus.req_wdata[15:0]}} : bus.req_wdata;
  assign rword = mem[idx];
  assign rbyte = rword[{lane, 3'b000} +: 8];
  assign rhalf = rword[{lane[1], 4'b0000} +: 16];
  assign ld = bus.req_size == 2'b00 ? {{24{!bus.req_unsigned && rbyte[7]}}, rbyte} :
              bus.req_size == 2'b01 ? {{16{!bus.req_unsigned && rhalf[15]}}, rhalf} : rword;
  always_ff @(posedge clock)
    if (we)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[idx][8*b +: 8] <= wd[8*b +: 8];
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE && accept) state_d = RESP;
    if (state_q == RESP && bus.rsp_ready) state_d = IDLE;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rdata_q <= (err || bus.req_write) ? 32'h0 : ld;
        error_q <= err;
      end else if (state_q == RESP && bus.rsp_ready) begin
        rdata_q <= '0;
        error_q <= 1'b0;
      end
    end
  end
  assign bus.rsp_valid = state_q == RESP;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_error = error_q;
endmodule
